// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache miss interface: one outstanding read/write, fixed latency.
// Optional MEM_STATS_EN adds saturating read/write completion counters (stat_reads, stat_writes).
module cache_mem_responder #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata
`ifdef MEM_STATS_EN
    ,
    output logic [7:0]        stat_reads,
    output logic [7:0]        stat_writes
`endif
);
    // state | meaning
    // IDLE  | req_ready high, waiting for a request
    // WAIT  | request latched, latency counter running down
    // RESP  | response held until resp_ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_write_q, resp_write_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              commit, resp_hs, mem_we;
    logic [DATA_W-1:0] addr_pat;

    // Storage holds data XOR address, so an all-zero power-up image reads back as word i = i.
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign addr_pat = DATA_W'(addr_q);
    assign mem_we   = commit && write_q && !reset;

`ifdef MEM_STATS_EN
    logic [7:0] stat_reads_q, stat_reads_d;
    logic [7:0] stat_writes_q, stat_writes_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        resp_valid_d = resp_valid_q;
        resp_write_d = resp_write_q;
        resp_rdata_d = resp_rdata_q;
        commit       = 1'b0;
        resp_hs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit       = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_write_d = write_q;
                    resp_rdata_d = write_q ? wdata_q : (mem_q[addr_q] ^ addr_pat);
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_hs      = 1'b1;
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_STATS_EN
    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (resp_hs && !write_q && stat_reads_q != 8'hFF)
            stat_reads_d = stat_reads_q + 8'd1;
        if (resp_hs && write_q && stat_writes_q != 8'hFF)
            stat_writes_d = stat_writes_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads_q  <= 8'd0;
            stat_writes_q <= 8'd0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Array is deliberately outside reset: committed write-backs survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem_q[addr_q] <= wdata_q ^ addr_pat;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder against a word-array reference model.
// A second instance built with LATENCY=1 covers the shortest-latency configuration.
module tb_cache_mem_responder;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int LAT    = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid, resp_ready = 1'b0, resp_write;
    logic [DATA_W-1:0] resp_rdata;

    logic              d1_req_valid = 1'b0, d1_req_ready, d1_req_write = 1'b0;
    logic [ADDR_W-1:0] d1_req_addr = '0;
    logic [DATA_W-1:0] d1_req_wdata = '0;
    logic              d1_resp_valid, d1_resp_ready = 1'b0, d1_resp_write;
    logic [DATA_W-1:0] d1_resp_rdata;

`ifdef MEM_STATS_EN
    logic [7:0] stat_reads, stat_writes, d1_stat_reads, d1_stat_writes;
`endif

    cache_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_write(resp_write), .resp_rdata(resp_rdata)
`ifdef MEM_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
    );

    cache_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_write(d1_req_write),
        .req_addr(d1_req_addr), .req_wdata(d1_req_wdata),
        .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready),
        .resp_write(d1_resp_write), .resp_rdata(d1_resp_rdata)
`ifdef MEM_STATS_EN
        , .stat_reads(d1_stat_reads), .stat_writes(d1_stat_writes)
`endif
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model [32];
    int         exp_reads  = 0;
    int         exp_writes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_txn(input logic wr, input logic [4:0] a, input logic [7:0] d, input int stall);
        int         n;
        logic [7:0] exp;
        check_val("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0;
        req_addr  = 5'($urandom);
        req_wdata = 8'($urandom);
        req_write = 1'($urandom);
        if (wr) model[a] = d;
        exp = model[a];
        n = 0;
        while (!resp_valid && n < 4 * LAT + 8) begin
            check_val("req_ready_busy", req_ready, 0);
            req_valid  = 1'($urandom);
            resp_ready = 1'($urandom);
            tick;
            n++;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        check_val("resp_latency", n, LAT);
        check_val("resp_rdata", resp_rdata, exp);
        check_val("resp_write", resp_write, wr);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'($urandom);
            req_addr  = 5'($urandom);
            tick;
            check_val("stall_valid", resp_valid, 1);
            check_val("stall_rdata", resp_rdata, exp);
            check_val("stall_write", resp_write, wr);
            check_val("stall_req_ready", req_ready, 0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        check_val("hs_valid_drop", resp_valid, 0);
        check_val("hs_req_ready", req_ready, 1);
        if (wr) begin
            if (exp_writes < 255) exp_writes++;
        end else begin
            if (exp_reads < 255) exp_reads++;
        end
    endtask

    // Write accepted, then reset lands after wait_cycles more edges (at or before the commit edge).
    task automatic abort_write(input logic [4:0] a, input logic [7:0] d, input int wait_cycles);
        check_val("abort_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            check_val("abort_wait_valid", resp_valid, 0);
            tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_reads = 0; exp_writes = 0;
        check_val("abort_rdata_clr", resp_rdata, 0);
        check_val("abort_write_clr", resp_write, 0);
        for (int i = 0; i < 3; i++) begin
            check_val("abort_no_resp", resp_valid, 0);
            check_val("abort_ready_back", req_ready, 1);
            tick;
        end
    endtask

    initial begin
        int         n;
        logic [4:0] ra, last_a;
        logic [7:0] rd;
        for (int i = 0; i < 32; i++) model[i] = 8'(i);

        tick; tick;
        reset = 1'b0;
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_resp_write", resp_write, 0);
        check_val("rst_resp_rdata", resp_rdata, 0);
        check_val("rst_req_ready", req_ready, 1);

        do_txn(1'b0, 5'd5, 8'h00, 0);
        check_val("read5_value", resp_rdata, 8'h05);
        do_txn(1'b1, 5'd17, 8'hA5, 1);
        do_txn(1'b0, 5'd17, 8'h00, 0);
        check_val("raw17_value", resp_rdata, 8'hA5);
        do_txn(1'b0, 5'd9, 8'h00, 5);

        abort_write(5'd2, 8'h3C, 1);
        do_txn(1'b0, 5'd2, 8'h00, 0);
        check_val("abort2_value", resp_rdata, 8'h02);
        abort_write(5'd2, 8'h77, LAT - 1);
        do_txn(1'b0, 5'd2, 8'h00, 0);
        check_val("abort2_commit_edge", resp_rdata, 8'h02);

        check_val("l1_ready", d1_req_ready, 1);
        d1_req_valid = 1'b1; d1_req_write = 1'b0; d1_req_addr = 5'd31;
        tick;
        d1_req_valid = 1'b0;
        n = 0;
        while (!d1_resp_valid && n < 10) begin
            tick;
            n++;
        end
        check_val("l1_latency", n, 1);
        check_val("l1_rdata", d1_resp_rdata, 8'h1F);
        check_val("l1_write", d1_resp_write, 0);
        d1_resp_ready = 1'b1;
        tick;
        d1_resp_ready = 1'b0;
        check_val("l1_ready_back", d1_req_ready, 1);

        last_a = 5'd0;
        for (int t = 0; t < 60; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? last_a : 5'($urandom);
            rd = 8'($urandom);
            if ($urandom_range(0, 9) == 0)
                abort_write(ra, rd, $urandom_range(0, LAT - 1));
            else
                do_txn(1'($urandom), ra, rd, $urandom_range(0, 5));
            last_a = ra;
        end

`ifdef MEM_STATS_EN
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_reads = 0; exp_writes = 0;
        check_val("stat_reads_rst", stat_reads, 0);
        check_val("stat_writes_rst", stat_writes, 0);
        for (int i = 0; i < 3; i++) do_txn(1'b0, 5'($urandom), 8'h00, 0);
        for (int i = 0; i < 2; i++) do_txn(1'b1, 5'($urandom), 8'($urandom), 0);
        check_val("stat_reads_3", stat_reads, 3);
        check_val("stat_writes_2", stat_writes, 2);
        for (int i = 0; i < 300; i++) do_txn(1'b0, 5'($urandom), 8'h00, 0);
        check_val("stat_reads_sat", stat_reads, 255);
        check_val("stat_writes_hold", stat_writes, exp_writes);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
